// File: rtl/neighborhood_fetch_pkg.sv
// -----------------------------------------------------------------------------
// neighborhood_fetch_pkg
//   Shared JPEG-LS decoder constants for the neighbourhood generator.
//   Holds the default sample width and frame geometry used by
//   neighborhood_fetch, its interface and its line buffer. It also holds a
//   helper that sizes counters so that a degenerate 1-row frame still gets
//   a 1-bit row counter.
// -----------------------------------------------------------------------------
package neighborhood_fetch_pkg;

    // Default sample width in bits.
    localparam int unsigned jls_pixel_length = 8;

    // Default frame geometry in pixels.
    localparam int unsigned jls_line_width   = 512;
    localparam int unsigned jls_frame_height = 512;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neighborhood_fetch_if.sv
// -----------------------------------------------------------------------------
// neighborhood_fetch_if
//   Neighbourhood hand-off between the neighbourhood generator (master) and
//   the gradient/context stage plus pixel reconstruction (slave).
//
//   nb_valid  : master -> slave, a/b/c/d/x/y are valid
//   nb_ready  : slave -> master, neighbourhood accepted
//   a,b,c,d   : master -> slave, left / above / above-left / above-right
//   x, y      : master -> slave, column and row of the current pixel
//   rec_valid : slave -> master, reconstructed pixel strobe
//   rec_pixel : slave -> master, reconstructed value of (x, y)
// -----------------------------------------------------------------------------
interface neighborhood_fetch_if
    import neighborhood_fetch_pkg::*;
#(
    parameter int unsigned pixel_length = jls_pixel_length,
    parameter int unsigned x_bits       = bits_for(jls_line_width),
    parameter int unsigned y_bits       = bits_for(jls_frame_height)
);

    logic                    nb_valid;
    logic                    nb_ready;
    logic [pixel_length-1:0] a;
    logic [pixel_length-1:0] b;
    logic [pixel_length-1:0] c;
    logic [pixel_length-1:0] d;
    logic [x_bits-1:0]       x;
    logic [y_bits-1:0]       y;
    logic                    rec_valid;
    logic [pixel_length-1:0] rec_pixel;

    modport master (
        output nb_valid, a, b, c, d, x, y,
        input  nb_ready, rec_valid, rec_pixel
    );

    modport slave (
        input  nb_valid, a, b, c, d, x, y,
        output nb_ready, rec_valid, rec_pixel
    );

endinterface

// File: rtl/neighborhood_fetch_linebuf.sv
// -----------------------------------------------------------------------------
// LineBuffer
//   Simple dual-port row store, line_width x pixel_length. One write port and
//   one registered read port (one-cycle latency). A read of the address being
//   written in the same cycle returns the old contents.
//
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write column
//   wr_data : sample to store
//   rd_addr : read column, sampled every cycle
//   rd_data : contents of rd_addr from the previous cycle
// -----------------------------------------------------------------------------
module LineBuffer
    import neighborhood_fetch_pkg::*;
#(
    parameter int unsigned pixel_length = jls_pixel_length,
    parameter int unsigned line_width   = jls_line_width,
    parameter int unsigned addr_bits    = bits_for(jls_line_width)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [addr_bits-1:0]    wr_addr,
    input  logic [pixel_length-1:0] wr_data,
    input  logic [addr_bits-1:0]    rd_addr,
    output logic [pixel_length-1:0] rd_data
);

    logic [pixel_length-1:0] mem [line_width];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/neighborhood_fetch.sv
// -----------------------------------------------------------------------------
// neighborhood_fetch
//   JPEG-LS decoder causal-neighbourhood generator. Keeps the previous
//   reconstructed row in a line buffer and presents a (left), b (above),
//   c (above-left) and d (above-right) for each pixel in raster order. The
//   write-back of the reconstructed pixel releases the next neighbourhood.
//
//   clk        : clock
//   reset_n    : synchronous active-low reset
//   start      : frame-start pulse, honoured only while idle
//   frame_done : one-cycle pulse after the last pixel is written back
//   nb         : neighbourhood / write-back interface (master side)
// -----------------------------------------------------------------------------
module neighborhood_fetch
    import neighborhood_fetch_pkg::*;
#(
    parameter int unsigned pixel_length = jls_pixel_length,
    parameter int unsigned line_width   = jls_line_width,
    parameter int unsigned frame_height = jls_frame_height,
    parameter int unsigned x_bits       = bits_for(line_width),
    parameter int unsigned y_bits       = bits_for(frame_height)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 frame_done,
    neighborhood_fetch_if.master nb
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_REC,
        ADVANCE
    } state_t;

    localparam logic [x_bits-1:0] x_last = x_bits'(line_width - 1);
    localparam logic [x_bits-1:0] x_penult = x_bits'(line_width - 2);
    localparam logic [y_bits-1:0] y_last = y_bits'(frame_height - 1);

    state_t state;
    state_t state_nxt;

    logic                    start_q;
    logic [x_bits-1:0]       x_q;
    logic [y_bits-1:0]       y_q;
    logic [pixel_length-1:0] a_q;
    logic [pixel_length-1:0] b_q;
    logic [pixel_length-1:0] c_q;
    logic [pixel_length-1:0] d_q;
    logic [pixel_length-1:0] p_q;          // pixel just written back
    logic [pixel_length-1:0] col0_cur_q;   // P[y][0] of the current row
    logic [pixel_length-1:0] col0_prev_q;  // P[y-1][0], 0 for row 0

    logic                    rec_take;
    logic                    at_row_end;
    logic                    at_frame_end;
    logic [x_bits-1:0]       rd_addr;
    logic [pixel_length-1:0] rd_data;

    assign at_row_end   = (x_q == x_last);
    assign at_frame_end = at_row_end && (y_q == y_last);

    assign nb.a = a_q;
    assign nb.b = b_q;
    assign nb.c = c_q;
    assign nb.d = d_q;
    assign nb.x = x_q;
    assign nb.y = y_q;

    LineBuffer #(
        .pixel_length (pixel_length),
        .line_width   (line_width),
        .addr_bits    (x_bits)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (rec_take),
        .wr_addr (x_q),
        .wr_data (nb.rec_pixel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The read for the next pixel's d is issued in WAIT_REC so the data lands
    // in ADVANCE. Mid-row that is column x+2. At row end it is column 1 of the
    // row just finished. The last column reuses b, so no read is needed there.
    always_comb begin
        rd_addr = '0;
        if (at_row_end) begin
            rd_addr = x_bits'(1);
        end else if (x_q < x_penult) begin
            rd_addr = x_q + x_bits'(2);
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_done  = 1'b0;
        nb.nb_valid = 1'b0;
        rec_take    = 1'b0;
        case (state)
            IDLE: begin
                if (start_q) begin
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                nb.nb_valid = 1'b1;
                if (nb.nb_ready) begin
                    state_nxt = WAIT_REC;
                end
            end
            WAIT_REC: begin
                if (nb.rec_valid) begin
                    rec_take  = 1'b1;
                    state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                if (at_frame_end) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = PRESENT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            p_q         <= '0;
            col0_cur_q  <= '0;
            col0_prev_q <= '0;
        end else begin
            state <= state_nxt;
            // start is registered, so (0,0) is presented two cycles after the
            // pulse. Gating with IDLE drops a pulse that arrives while busy.
            start_q <= start && (state == IDLE);

            case (state)
                IDLE: begin
                    if (start_q) begin
                        x_q <= '0;
                        y_q <= '0;
                        a_q <= '0;
                        b_q <= '0;
                        c_q <= '0;
                        d_q <= '0;
                    end
                end
                WAIT_REC: begin
                    if (rec_take) begin
                        p_q <= nb.rec_pixel;
                        if (x_q == '0) begin
                            // Column 0 of the row about to be overwritten is
                            // still needed as c at the start of the next row.
                            col0_cur_q  <= nb.rec_pixel;
                            col0_prev_q <= b_q;
                        end
                    end
                end
                ADVANCE: begin
                    if (!at_frame_end) begin
                        if (at_row_end) begin
                            x_q <= '0;
                            y_q <= y_q + y_bits'(1);
                            a_q <= col0_cur_q;
                            b_q <= col0_cur_q;
                            c_q <= col0_prev_q;
                            // With a 2-pixel row, column 1 was written in the
                            // same cycle it was read, so take the written value.
                            d_q <= (line_width == 2) ? p_q : rd_data;
                        end else begin
                            x_q <= x_q + x_bits'(1);
                            a_q <= p_q;
                            if (y_q == '0) begin
                                b_q <= '0;
                                c_q <= '0;
                                d_q <= '0;
                            end else begin
                                // The above row slides left by one: d->b, b->c.
                                b_q <= d_q;
                                c_q <= b_q;
                                d_q <= (x_q == x_penult) ? d_q : rd_data;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neighborhood_fetch.sv
module tb_neighborhood_fetch;

    localparam int LW = 4;
    localparam int FH = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic frame_done;

    int vectors     = 0;
    int miscompares = 0;

    int pix [FH][LW];

    neighborhood_fetch_if #(.pixel_length(8), .x_bits(2), .y_bits(2)) nb ();

    neighborhood_fetch #(
        .pixel_length (8),
        .line_width   (LW),
        .frame_height (FH),
        .x_bits       (2),
        .y_bits       (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .frame_done (frame_done),
        .nb         (nb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ex, ey, ea, eb, ec, ed;
        int pix;
        int hold;
        bit spur;
        bit busy_start;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neighbourhood of (x, y) derived from the raster rules over the picture.
    function automatic void model_nb(input int x, input int y,
                                     output int ea, output int eb,
                                     output int ec, output int ed);
        if (y == 0) begin
            ea = (x == 0) ? 0 : pix[0][x-1];
            eb = 0;
            ec = 0;
            ed = 0;
        end else if (x == 0) begin
            ea = pix[y-1][0];
            eb = ea;
            ec = (y == 1) ? 0 : pix[y-2][0];
            ed = pix[y-1][1];
        end else begin
            ea = pix[y][x-1];
            eb = pix[y-1][x];
            ec = pix[y-1][x-1];
            ed = (x == LW - 1) ? eb : pix[y-1][x+1];
        end
    endfunction

    task automatic check_nb(input string tag, input int ex, input int ey,
                            input int ea, input int eb, input int ec, input int ed);
        check({tag, "_x"}, nb.x, ex);
        check({tag, "_y"}, nb.y, ey);
        check({tag, "_a"}, nb.a, ea);
        check({tag, "_b"}, nb.b, eb);
        check({tag, "_c"}, nb.c, ec);
        check({tag, "_d"}, nb.d, ed);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_lat1_valid", nb.nb_valid, 0);
        tick();
        check("start_lat2_valid", nb.nb_valid, 1);
    endtask

    // One pixel: wait for the neighbourhood, optionally stall, hand it off,
    // write back after recdly cycles, then check the write-back latency.
    task automatic do_pixel(input vec_t v, input int recdly);
        int  waited = 0;
        bit  last;
        while (nb.nb_valid !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("nb_valid_wait", nb.nb_valid, 1);
        check_nb("pres", v.ex, v.ey, v.ea, v.eb, v.ec, v.ed);

        if (v.busy_start) start = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            nb.nb_ready = 1'b0;
            if (v.spur) begin
                nb.rec_valid = 1'b1;
                nb.rec_pixel = 8'hEE;
            end
            tick();
            start        = 1'b0;
            nb.rec_valid = 1'b0;
            check("hold_valid", nb.nb_valid, 1);
            check_nb("hold", v.ex, v.ey, v.ea, v.eb, v.ec, v.ed);
        end

        nb.nb_ready = 1'b1;
        tick();
        nb.nb_ready = 1'b0;
        start       = 1'b0;
        check("valid_drop", nb.nb_valid, 0);

        for (int i = 0; i < recdly; i++) begin
            tick();
            check("wait_rec_valid", nb.nb_valid, 0);
        end

        nb.rec_valid = 1'b1;
        nb.rec_pixel = v.pix[7:0];
        tick();
        nb.rec_valid = 1'b0;
        last = (v.ex == LW - 1) && (v.ey == FH - 1);
        check("frame_done_adv", frame_done, last);
        check("adv_valid", nb.nb_valid, 0);
        tick();
        check(last ? "idle_valid" : "rec_latency_valid", nb.nb_valid, !last);
        check("frame_done_after", frame_done, 0);
    endtask

    task automatic random_frame();
        vec_t v;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < LW; x++) begin
                v.ex = x;
                v.ey = y;
                model_nb(x, y, v.ea, v.eb, v.ec, v.ed);
                v.pix        = int'($urandom_range(0, 255));
                v.hold       = int'($urandom_range(0, 3));
                v.spur       = 1'($urandom_range(0, 1));
                v.busy_start = ($urandom_range(0, 7) == 0);
                do_pixel(v, int'($urandom_range(0, 3)));
                pix[y][x] = v.pix;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // P[y][x] = 10y + x + 1, immediate write-back.
        tbl[0]  = '{0, 0,  0,  0,  0,  0,  1, 0, 0, 0};
        tbl[1]  = '{1, 0,  1,  0,  0,  0,  2, 0, 0, 0};
        tbl[2]  = '{2, 0,  2,  0,  0,  0,  3, 0, 0, 0};
        tbl[3]  = '{3, 0,  3,  0,  0,  0,  4, 0, 0, 0};
        tbl[4]  = '{0, 1,  1,  1,  0,  2, 11, 0, 0, 0};
        tbl[5]  = '{1, 1, 11,  2,  1,  3, 12, 5, 1, 0};
        tbl[6]  = '{2, 1, 12,  3,  2,  4, 13, 0, 0, 0};
        tbl[7]  = '{3, 1, 13,  4,  3,  4, 14, 0, 0, 0};
        tbl[8]  = '{0, 2, 11, 11,  1, 12, 21, 0, 0, 0};
        tbl[9]  = '{1, 2, 21, 12, 11, 13, 22, 0, 0, 1};
        tbl[10] = '{2, 2, 22, 13, 12, 14, 23, 0, 0, 0};
        tbl[11] = '{3, 2, 23, 14, 13, 14, 24, 0, 0, 0};

        reset_n      = 1'b0;
        start        = 1'b0;
        nb.nb_ready  = 1'b0;
        nb.rec_valid = 1'b0;
        nb.rec_pixel = '0;
        tick();
        check("rst_valid", nb.nb_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check_nb("rst", 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Directed frame from the table; ends with a back-to-back start.
        start_frame();
        for (int i = 0; i < 12; i++) do_pixel(tbl[i], 0);
        check("done_idle_valid", nb.nb_valid, 0);

        // Randomized frames, the first one started in the IDLE cycle right
        // after frame_done.
        for (int f = 0; f < 5; f++) begin
            start_frame();
            random_frame();
        end

        // Partial frame abandoned by a reset at (2,1).
        start_frame();
        for (int i = 0; i < 6; i++) do_pixel(tbl[i], 0);
        check_nb("pre_rst", 2, 1, 12, 3, 2, 4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_valid", nb.nb_valid, 0);
        check("midrst_done", frame_done, 0);
        check_nb("midrst", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_idle_valid", nb.nb_valid, 0);
        end

        // Fresh frame after the reset reproduces the directed results.
        start_frame();
        for (int i = 0; i < 12; i++) do_pixel(tbl[i], 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("final_idle_valid", nb.nb_valid, 0);
            check("final_idle_done", frame_done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
